// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: FSM state encodings and PS/2 command codes shared by the host transmitter.
package ps2_host_tx_pkg;
  typedef logic [7:0] cmd_t;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_RTS     = 3'd2,
    ST_SEND    = 3'd3,
    ST_ACK     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;
  localparam cmd_t CMD_LEDS   = 8'hED;
  localparam cmd_t CMD_ENABLE = 8'hF4;
  localparam cmd_t CMD_RESET  = 8'hFF;
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake plus open-collector line controls of the PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_host_tx_pkg::*;
  logic tx_start;
  cmd_t tx_data;
  logic ps2c_in;
  logic ps2d_in;
  logic ps2c_oe;
  logic ps2d_oe;
  logic tx_busy;
  logic tx_done;
  logic tx_err;
  modport master (
    output tx_start, tx_data, ps2c_in, ps2d_in,
    input  ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err
  );
  modport slave (
    input  tx_start, tx_data, ps2c_in, ps2d_in,
    output ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_filtro_flanco.sv
// ps2_filtro_flanco: synchronizes the raw PS/2 clock, filters glitches over FILTER_LEN samples
// and pulses o_fall_tick for one cycle on a filtered high-to-low transition.
module ps2_filtro_flanco #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic o_fall_tick
);
  logic [1:0]            r_sync;
  logic [FILTER_LEN-1:0] r_hist;
  logic                  r_level;
  logic                  w_all0;
  logic                  w_all1;
  assign w_all0      = ~|r_hist;
  assign w_all1      = &r_hist;
  assign o_fall_tick = r_level & w_all0;
  // History and level reset to ones: an idle PS/2 line floats high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync  <= 2'b11;
      r_hist  <= '1;
      r_level <= 1'b1;
    end else begin
      r_sync  <= {r_sync[0], i_line};
      r_hist  <= FILTER_LEN'({r_hist, r_sync[1]});
      r_level <= w_all1 ? 1'b1 : w_all0 ? 1'b0 : r_level;
    end
  end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command sender: request-to-send, LSB-first byte with odd
// parity on device clock falls, acknowledge check, gap timeout and done/error reporting.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FILTER_LEN     = 8
) (
  input logic          clk,
  input logic          reset,
  ps2_host_tx_if.slave bus
);
  localparam int CW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [3:0]    r_bits, w_bits_n;
  logic [8:0]    r_shift, w_shift_n;
  logic          r_dsend, w_dsend_n;
  logic          r_err, w_err_n;
  logic [1:0]    r_dsync;
  logic          w_tick;
  logic          w_timeout;
  ps2_filtro_flanco #(.FILTER_LEN(FILTER_LEN)) u_filtro (
    .clk         (clk),
    .reset       (reset),
    .i_line      (bus.ps2c_in),
    .o_fall_tick (w_tick)
  );
  assign w_timeout   = r_cnt == CW'(TIMEOUT_CYCLES);
  assign bus.ps2c_oe = (r_state == ST_INHIBIT) || (r_state == ST_RTS);
  assign bus.ps2d_oe = (r_state == ST_RTS) || ((r_state == ST_SEND) && r_dsend);
  assign bus.tx_busy = r_state != ST_IDLE;
  assign bus.tx_done = r_state == ST_DONE;
  assign bus.tx_err  = (r_state == ST_DONE) && r_err;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_shift <= '0;
      r_dsend <= 1'b0;
      r_err   <= 1'b0;
      r_dsync <= 2'b11;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bits  <= w_bits_n;
      r_shift <= w_shift_n;
      r_dsend <= w_dsend_n;
      r_err   <= w_err_n;
      r_dsync <= {r_dsync[0], bus.ps2d_in};
    end
  end
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bits_n  = r_bits;
    w_shift_n = r_shift;
    w_dsend_n = r_dsend;
    w_err_n   = r_err;
    case (r_state)
      ST_IDLE: if (bus.tx_start) begin
        w_shift_n = {~^bus.tx_data, bus.tx_data};
        w_cnt_n   = '0;
        w_bits_n  = '0;
        w_err_n   = 1'b0;
        w_state_n = ST_INHIBIT;
      end
      ST_INHIBIT: begin
        w_cnt_n = r_cnt + CW'(1);
        if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
          w_cnt_n   = '0;
          w_state_n = ST_RTS;
        end
      end
      ST_RTS: begin
        w_cnt_n   = '0;
        w_bits_n  = '0;
        w_dsend_n = 1'b1;
        w_state_n = ST_SEND;
      end
      // A tick takes priority over an expiring gap counter.
      ST_SEND: if (w_tick) begin
        w_cnt_n   = '0;
        w_bits_n  = r_bits + 4'd1;
        w_dsend_n = (r_bits == 4'd9) ? 1'b0 : ~r_shift[0];
        w_shift_n = (r_bits == 4'd9) ? r_shift : r_shift >> 1;
        w_state_n = (r_bits == 4'd9) ? ST_ACK : ST_SEND;
      end else if (w_timeout) begin
        w_dsend_n = 1'b0;
        w_err_n   = 1'b1;
        w_state_n = ST_DONE;
      end else begin
        w_cnt_n = r_cnt + CW'(1);
      end
      ST_ACK: if (w_tick) begin
        w_bits_n  = r_bits + 4'd1;
        w_err_n   = r_dsync[1];
        w_state_n = ST_DONE;
      end else if (w_timeout) begin
        w_err_n   = 1'b1;
        w_state_n = ST_DONE;
      end else begin
        w_cnt_n = r_cnt + CW'(1);
      end
      ST_DONE: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end
endmodule
